wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: decodes the retiring instruction into a
// GPR write and serves two decode-stage read ports with same-cycle bypass.

module wb_regfile_rdport (
  input  logic [4:0]        rd_addr,
  input  logic [31:0][31:0] regs,
  input  logic              byp_en,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic [31:0]       rd_data
);
  always_comb begin
    rd_data = regs[rd_addr];
    if (rd_addr == 5'd0)                         rd_data = '0;
    else if (byp_en && (rd_addr == wb_addr))     rd_data = wb_data;
  end
endmodule

module wb_regfile #(
  parameter logic [31:0] GP_INIT = 32'h00001800,
  parameter logic [31:0] SP_INIT = 32'h00002ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_B,
  input  logic [31:0] pc4_B,
  input  logic [31:0] alu_B,
  input  logic [31:0] memdata_B,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);
  localparam int NUM_RD = 2;

  typedef enum logic [1:0] { SRC_ALU, SRC_LINK, SRC_LOAD } src_e;
  typedef enum logic [2:0] { LD_W, LD_B, LD_BU, LD_H, LD_HU } ld_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  logic [5:0]  opcode, funct;
  logic        dec_vld;
  logic [4:0]  dec_dst;
  src_e        dec_src;
  ld_e         dec_ld;
  logic [31:0] link_val, load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  wb_req_t     wb;

  assign opcode = instr_B[31:26];
  assign funct  = instr_B[5:0];

  always_comb begin
    dec_vld = 1'b0;
    dec_dst = '0;
    dec_src = SRC_ALU;
    dec_ld  = LD_W;
    unique case (opcode)
      6'h00: begin
        // jr and the all-zero bubble retire without a register write
        if ((instr_B != '0) && (funct != 6'h08)) begin
          dec_vld = 1'b1;
          dec_dst = instr_B[15:11];
          dec_src = (funct == 6'h09) ? SRC_LINK : SRC_ALU;
        end
      end
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec_vld = 1'b1;
        dec_dst = instr_B[20:16];
      end
      6'h23, 6'h20, 6'h24, 6'h21, 6'h25: begin
        dec_vld = 1'b1;
        dec_dst = instr_B[20:16];
        dec_src = SRC_LOAD;
        unique case (opcode)
          6'h20:   dec_ld = LD_B;
          6'h24:   dec_ld = LD_BU;
          6'h21:   dec_ld = LD_H;
          6'h25:   dec_ld = LD_HU;
          default: dec_ld = LD_W;
        endcase
      end
      6'h03: begin
        dec_vld = 1'b1;
        dec_dst = 5'd31;
        dec_src = SRC_LINK;
      end
      default: ;
    endcase
  end

  // Delay-slot semantics: the link points past the slot instruction.
  assign link_val = pc4_B + 32'd4;

  always_comb begin
    unique case (alu_B[1:0])
      2'd0: ld_byte = memdata_B[7:0];
      2'd1: ld_byte = memdata_B[15:8];
      2'd2: ld_byte = memdata_B[23:16];
      default: ld_byte = memdata_B[31:24];
    endcase
    ld_half = alu_B[1] ? memdata_B[31:16] : memdata_B[15:0];
    unique case (dec_ld)
      LD_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   load_val = {24'd0, ld_byte};
      LD_H:    load_val = {{16{ld_half[15]}}, ld_half};
      LD_HU:   load_val = {16'd0, ld_half};
      default: load_val = memdata_B;
    endcase
  end

  always_comb begin
    wb.we   = dec_vld && (dec_dst != 5'd0);
    wb.addr = dec_dst;
    unique case (dec_src)
      SRC_LINK: wb.data = link_val;
      SRC_LOAD: wb.data = load_val;
      default:  wb.data = alu_B;
    endcase
  end

  assign wb_we   = wb.we;
  assign wb_addr = wb.addr;
  assign wb_data = wb.data;

  logic [31:0][31:0] gpr_q, gpr_d;

  always_comb begin
    gpr_d = gpr_q;
    if (wb.we) gpr_d[wb.addr] = wb.data;
    gpr_d[0] = '0;
  end

  // An edge seen while reset is low is swallowed by the async clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpr_q     <= '0;
      gpr_q[28] <= GP_INIT;
      gpr_q[29] <= SP_INIT;
    end else begin
      gpr_q <= gpr_d;
    end
  end

  logic [NUM_RD-1:0][4:0]  rd_addr_v;
  logic [NUM_RD-1:0][31:0] rd_data_v;

  assign rd_addr_v = {rt_addr, rs_addr};

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      wb_regfile_rdport u_rdport (
        .rd_addr (rd_addr_v[g]),
        .regs    (gpr_q),
        .byp_en  (wb.we && reset),
        .wb_addr (wb.addr),
        .wb_data (wb.data),
        .rd_data (rd_data_v[g])
      );
    end
  endgenerate

  assign rs_data = rd_data_v[0];
  assign rt_data = rd_data_v[1];
endmodule
